// File: rtl/switch_input_ctrl_if.sv
// Slave bus bundle for switch_input_ctrl.
// Signals (named from the slave's point of view):
//   iChip_select_n  slave select, active low
//   iRead_n         read strobe, active low
//   iWrite_n        write strobe, active low
//   iAddress        word address: 0 DATA, 1 EDGE, 2 MASK, 3 RAW
//   iWritedata      write data
//   oReaddata       registered read data
interface switch_input_ctrl_if;
  logic        iChip_select_n;
  logic        iRead_n;
  logic        iWrite_n;
  logic [1:0]  iAddress;
  logic [31:0] iWritedata;
  logic [31:0] oReaddata;

  modport master (
    output iChip_select_n, iRead_n, iWrite_n, iAddress, iWritedata,
    input  oReaddata
  );

  modport slave (
    input  iChip_select_n, iRead_n, iWrite_n, iAddress, iWritedata,
    output oReaddata
  );
endinterface

// File: rtl/switch_input_ctrl.sv
// Memory-mapped switch/GPIO input peripheral: per-channel synchroniser,
// debounce, sticky W1C change flags, interrupt mask and a level IRQ.
// Ports:
//   iClk            system clock
//   iReset_n        synchronous active-low reset
//   bus             slave bus (select, strobes, address, write/read data)
//   iSwitches_data  asynchronous switch levels, NUM_SW wide
//   oIrq            registered level interrupt, |(EDGE & MASK)
// Register map (word address): 0 DATA (RO), 1 EDGE (W1C), 2 MASK (RW), 3 RAW (RO).
module switch_input_ctrl #(
  parameter int NUM_SW          = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                iClk,
  input  logic                iReset_n,
  switch_input_ctrl_if.slave  bus,
  input  logic [NUM_SW-1:0]   iSwitches_data,
  output logic                oIrq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SW-1:0] raw;
  logic [NUM_SW-1:0] data_q, data_d;
  logic [NUM_SW-1:0] edge_q, edge_d;
  logic [NUM_SW-1:0] mask_q, mask_d;
  logic [CW-1:0]     cnt_q [NUM_SW];
  logic [CW-1:0]     cnt_d [NUM_SW];
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic              rd_en, wr_en;

  assign raw   = sync_q[SYNC_STAGES-1];
  assign rd_en = !bus.iChip_select_n && !bus.iRead_n;
  // A simultaneous read strobe turns the access into a read only.
  assign wr_en = !bus.iChip_select_n && !bus.iWrite_n && bus.iRead_n;

  always_comb begin : debounce_comb
    data_d = data_q;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (raw[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        data_d[i] = raw[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin : regs_comb
    edge_d  = edge_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    if (wr_en && bus.iAddress == ADDR_EDGE) begin
      edge_d = edge_q & ~bus.iWritedata[NUM_SW-1:0];
    end
    if (wr_en && bus.iAddress == ADDR_MASK) begin
      mask_d = bus.iWritedata[NUM_SW-1:0];
    end
    // New toggles are OR-ed in after the clear so a same-edge set wins.
    edge_d = edge_d | (data_d ^ data_q);
    irq_d  = |(edge_d & mask_d);
    if (rd_en) begin
      case (bus.iAddress)
        ADDR_DATA: rdata_d = 32'(data_q);
        ADDR_EDGE: rdata_d = 32'(edge_q);
        ADDR_MASK: rdata_d = 32'(mask_q);
        ADDR_RAW:  rdata_d = 32'(raw);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
      data_q  <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q[0] <= iSwitches_data;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= cnt_d[i];
      data_q  <= data_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.oReaddata = rdata_q;
  assign oIrq          = irq_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl: a default instance (32 ch, 2 sync,
// 16 debounce) and a small instance (8 ch, 2 sync, 1 debounce).
module tb_switch_input_ctrl;
  logic        clk;
  logic        rst_n;
  logic [31:0] sw_a;
  logic [7:0]  sw_b;
  logic        irq_a, irq_b;
  int          total, bad;
  logic [31:0] rd;

  switch_input_ctrl_if bus_a();
  switch_input_ctrl_if bus_b();

  switch_input_ctrl dut_a (
    .iClk(clk), .iReset_n(rst_n), .bus(bus_a.slave),
    .iSwitches_data(sw_a), .oIrq(irq_a)
  );

  switch_input_ctrl #(.NUM_SW(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut_b (
    .iClk(clk), .iReset_n(rst_n), .bus(bus_b.slave),
    .iSwitches_data(sw_b), .oIrq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_read(input logic [1:0] addr, output logic [31:0] d);
    bus_a.iChip_select_n = 1'b0; bus_a.iRead_n = 1'b0; bus_a.iAddress = addr;
    step(1);
    d = bus_a.oReaddata;
    bus_a.iChip_select_n = 1'b1; bus_a.iRead_n = 1'b1;
  endtask

  task automatic a_write(input logic [1:0] addr, input logic [31:0] d);
    bus_a.iChip_select_n = 1'b0; bus_a.iWrite_n = 1'b0;
    bus_a.iAddress = addr; bus_a.iWritedata = d;
    step(1);
    bus_a.iChip_select_n = 1'b1; bus_a.iWrite_n = 1'b1;
  endtask

  task automatic b_read(input logic [1:0] addr, output logic [31:0] d);
    bus_b.iChip_select_n = 1'b0; bus_b.iRead_n = 1'b0; bus_b.iAddress = addr;
    step(1);
    d = bus_b.oReaddata;
    bus_b.iChip_select_n = 1'b1; bus_b.iRead_n = 1'b1;
  endtask

  task automatic b_write(input logic [1:0] addr, input logic [31:0] d);
    bus_b.iChip_select_n = 1'b0; bus_b.iWrite_n = 1'b0;
    bus_b.iAddress = addr; bus_b.iWritedata = d;
    step(1);
    bus_b.iChip_select_n = 1'b1; bus_b.iWrite_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw_a = 32'hFFFF_FFFF; sw_b = 8'hFF;
    step(3);
    total++; if (bus_a.oReaddata !== 32'h0) begin bad++; $display("FAIL rst_rdata_a got=%h exp=0", bus_a.oReaddata); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL rst_irq_a got=%b exp=0", irq_a); end
    total++; if (bus_b.oReaddata !== 32'h0) begin bad++; $display("FAIL rst_rdata_b got=%h exp=0", bus_b.oReaddata); end
    total++; if (irq_b !== 1'b0) begin bad++; $display("FAIL rst_irq_b got=%b exp=0", irq_b); end
    sw_a = 32'h0; sw_b = 8'h0;
    step(3);
    rst_n = 1'b1;
    a_read(2'd0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", rd); end
    a_read(2'd1, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_edge got=%h exp=0", rd); end
  endtask

  task automatic test_debounce_latency();
    sw_a[0] = 1'b1;
    bus_a.iChip_select_n = 1'b0; bus_a.iRead_n = 1'b0; bus_a.iAddress = 2'd0;
    for (int e = 1; e <= 19; e++) begin
      step(1);
      // oReaddata after edge e shows DATA as it stood after edge e-1
      if (e == 18) begin
        total++; if (bus_a.oReaddata[0] !== 1'b0) begin bad++; $display("FAIL lat_edge17 got=%b exp=0", bus_a.oReaddata[0]); end
      end
      if (e == 19) begin
        total++; if (bus_a.oReaddata[0] !== 1'b1) begin bad++; $display("FAIL lat_edge18 got=%b exp=1", bus_a.oReaddata[0]); end
      end
    end
    bus_a.iChip_select_n = 1'b1; bus_a.iRead_n = 1'b1;
    a_read(2'd1, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL lat_edge_flag got=%h exp=1", rd); end
    a_write(2'd1, 32'h1);
    a_read(2'd1, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h exp=0", rd); end
    a_read(2'd0, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL lat_data_hold got=%h exp=1", rd); end
  endtask

  task automatic test_glitch();
    sw_a[3] = 1'b1;
    step(15);
    sw_a[3] = 1'b0;
    step(20);
    a_read(2'd0, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL glitch_data got=%h exp=1", rd); end
    a_read(2'd1, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL glitch_edge got=%h exp=0", rd); end
    total++; if (dut_a.cnt_q[3] !== 5'd0) begin bad++; $display("FAIL glitch_cnt got=%0d exp=0", dut_a.cnt_q[3]); end
  endtask

  task automatic test_irq();
    a_write(2'd2, 32'h1);
    a_read(2'd2, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL mask_read got=%h exp=1", rd); end
    sw_a[0] = 1'b0;
    step(17);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq_a); end
    step(1);
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL irq_assert got=%b exp=1", irq_a); end
    a_write(2'd1, 32'h1);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_deassert got=%b exp=0", irq_a); end
    sw_a[1] = 1'b1;
    step(20);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", irq_a); end
    a_read(2'd1, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL irq_masked_edge got=%h exp=2", rd); end
  endtask

  task automatic test_w1c_race();
    sw_a[2] = 1'b1;
    step(17);
    a_write(2'd1, 32'h4);   // executes on edge 18, the edge DATA[2] toggles
    a_read(2'd1, rd);
    total++; if (rd !== 32'h6) begin bad++; $display("FAIL race_edge got=%h exp=6", rd); end
    a_read(2'd1, rd);
    total++; if (rd !== 32'h6) begin bad++; $display("FAIL read_noclear got=%h exp=6", rd); end
    bus_a.iChip_select_n = 1'b0; bus_a.iRead_n = 1'b0; bus_a.iWrite_n = 1'b0;
    bus_a.iAddress = 2'd2; bus_a.iWritedata = 32'hFFFF_FFFF;
    step(1);
    bus_a.iChip_select_n = 1'b1; bus_a.iRead_n = 1'b1; bus_a.iWrite_n = 1'b1;
    total++; if (bus_a.oReaddata !== 32'h1) begin bad++; $display("FAIL rdwr_read got=%h exp=1", bus_a.oReaddata); end
    a_read(2'd2, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL rdwr_nowrite got=%h exp=1", rd); end
  endtask

  task automatic test_reset_mid_debounce();
    sw_a[4] = 1'b1;
    step(10);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    bus_a.iChip_select_n = 1'b0; bus_a.iRead_n = 1'b0; bus_a.iAddress = 2'd0;
    for (int e = 1; e <= 19; e++) begin
      step(1);
      if (e == 18) begin
        total++; if (bus_a.oReaddata !== 32'h0) begin bad++; $display("FAIL midrst_early got=%h exp=0", bus_a.oReaddata); end
      end
      if (e == 19) begin
        total++; if (bus_a.oReaddata !== 32'h16) begin bad++; $display("FAIL midrst_data got=%h exp=16", bus_a.oReaddata); end
      end
    end
    bus_a.iChip_select_n = 1'b1; bus_a.iRead_n = 1'b1;
    a_read(2'd1, rd);
    total++; if (rd !== 32'h16) begin bad++; $display("FAIL midrst_edge got=%h exp=16", rd); end
    a_read(2'd2, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_mask got=%h exp=0", rd); end
  endtask

  task automatic test_params();
    sw_b = 8'hA5;
    bus_b.iChip_select_n = 1'b0; bus_b.iRead_n = 1'b0; bus_b.iAddress = 2'd0;
    for (int e = 1; e <= 4; e++) begin
      step(1);
      if (e == 3) begin
        total++; if (bus_b.oReaddata !== 32'h0) begin bad++; $display("FAIL p_data_early got=%h exp=0", bus_b.oReaddata); end
      end
      if (e == 4) begin
        total++; if (bus_b.oReaddata !== 32'h0000_00A5) begin bad++; $display("FAIL p_data got=%h exp=a5", bus_b.oReaddata); end
      end
    end
    bus_b.iChip_select_n = 1'b1; bus_b.iRead_n = 1'b1;
    b_write(2'd2, 32'hFFFF_FFFF);
    total++; if (irq_b !== 1'b1) begin bad++; $display("FAIL p_irq got=%b exp=1", irq_b); end
    b_read(2'd2, rd);
    total++; if (rd !== 32'h0000_00FF) begin bad++; $display("FAIL p_mask got=%h exp=ff", rd); end
    b_read(2'd3, rd);
    total++; if (rd !== 32'h0000_00A5) begin bad++; $display("FAIL p_raw got=%h exp=a5", rd); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; sw_a = '0; sw_b = '0;
    bus_a.iChip_select_n = 1'b1; bus_a.iRead_n = 1'b1; bus_a.iWrite_n = 1'b1;
    bus_a.iAddress = 2'd0; bus_a.iWritedata = '0;
    bus_b.iChip_select_n = 1'b1; bus_b.iRead_n = 1'b1; bus_b.iWrite_n = 1'b1;
    bus_b.iAddress = 2'd0; bus_b.iWritedata = '0;
    @(negedge clk);
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_irq();
    test_w1c_race();
    test_reset_mid_debounce();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
